// File: rtl/ninjakun_hiscore_xfer.sv
// ninjakun_hiscore_xfer: pauses the core and copies a foreground-VRAM window to/from a hiscore buffer.
// Define HISCORE_VERIFY_EN to add a read-back compare pass after every load.
module ninjakun_hiscore_xfer #(
  parameter logic [10:0] HS_BASE = 11'h000,
  parameter int          HS_LEN  = 16,
  parameter int          GUARD   = 2
) (
  input  logic        ROMCL,
  input  logic        RESET_L,
  input  logic        SAVE_REQ,
  input  logic        LOAD_REQ,
  output logic        PAUSE_REQ,
  input  logic        pause,
  output logic [15:0] hs_address,
  output logic [7:0]  hs_data_in,
  input  logic [7:0]  hs_data_out,
  output logic        hs_write,
  output logic        hs_access,
  output logic [7:0]  BUF_ADR,
  input  logic [7:0]  BUF_DIN,
  output logic [7:0]  BUF_DOUT,
  output logic        BUF_WE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
`ifdef HISCORE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, REQ, GIN, XA, XB, VA, VB, GOUT, FIN} state_t;
  state_t st_q, st_d;
  logic [7:0] i_q, i_d, g_q, g_d;
  logic save_q, save_d, err_q, err_d;
  logic preq_q, busy_q, acc_q, wr_q, we_q, done_q, erro_q;
  logic last, gend, xfer;
  assign last = i_q == 8'(HS_LEN - 1);
  assign gend = g_q == 8'(GUARD - 1);
  always_comb begin
    st_d = st_q;
    i_d = i_q;
    g_d = g_q;
    save_d = save_q;
    err_d = err_q;
    case (st_q)
      IDLE: if (SAVE_REQ || LOAD_REQ) begin
        st_d = REQ;
        save_d = SAVE_REQ;
        err_d = 1'b0;
      end
      REQ: if (pause) begin
        st_d = GIN;
        g_d = '0;
      end
      GIN: begin
        st_d = gend ? XA : GIN;
        g_d = g_q + 8'd1;
        i_d = '0;
      end
      XA: st_d = XB;
      XB: begin
        st_d = last ? ((VERIFY && !save_q) ? VA : GOUT) : XA;
        i_d = last ? 8'd0 : i_q + 8'd1;
        g_d = '0;
      end
      VA: st_d = VB;
      VB: begin
        err_d = err_q | (BUF_DIN != hs_data_out);
        st_d = last ? GOUT : VA;
        i_d = i_q + 8'd1;
        g_d = '0;
      end
      GOUT: begin
        st_d = gend ? FIN : GOUT;
        g_d = g_q + 8'd1;
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    // losing pause while holding the port aborts; the pending strobe never issues
    if (!pause && (st_q inside {GIN, XA, XB, VA, VB})) begin
      st_d = GOUT;
      g_d = '0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge ROMCL) begin
    if (!RESET_L) begin
      st_q <= IDLE;
      i_q <= '0;
      g_q <= '0;
      save_q <= 1'b0;
      err_q <= 1'b0;
      preq_q <= 1'b0;
      busy_q <= 1'b0;
      acc_q <= 1'b0;
      wr_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      st_q <= st_d;
      i_q <= i_d;
      g_q <= g_d;
      save_q <= save_d;
      err_q <= err_d;
      preq_q <= st_d inside {REQ, GIN, XA, XB, VA, VB, GOUT};
      busy_q <= st_d != IDLE;
      acc_q <= st_d inside {GIN, XA, XB, VA, VB, GOUT};
      wr_q <= (st_d == XB) && !save_d;
      we_q <= (st_d == XB) && save_d;
      done_q <= st_d == FIN;
      erro_q <= (st_d == FIN) && err_d;
    end
  end
  assign xfer = st_q inside {XA, XB, VA, VB};
  assign hs_address = xfer ? {5'b0, HS_BASE + 11'(i_q)} : 16'h0;
  assign BUF_ADR = xfer ? i_q : 8'h0;
  assign hs_write = wr_q & pause;
  assign BUF_WE = we_q & pause;
  assign hs_data_in = hs_write ? BUF_DIN : 8'h0;
  assign BUF_DOUT = BUF_WE ? hs_data_out : 8'h0;
  assign PAUSE_REQ = preq_q;
  assign hs_access = acc_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR = erro_q;
endmodule

// File: tb/tb_ninjakun_hiscore_xfer.sv
// tb_ninjakun_hiscore_xfer: scoreboard bench with VRAM, buffer and pause-acknowledge models.
module tb_ninjakun_hiscore_xfer;
  localparam logic [10:0] BASE = 11'h7F8;
  localparam int LEN = 16;
  localparam int GUARD = 2;
`ifdef HISCORE_VERIFY_EN
  localparam int LOAD_LAT = 39 + 2 * LEN;
`else
  localparam int LOAD_LAT = 39;
`endif
  logic ROMCL = 0, RESET_L = 0, SAVE_REQ = 0, LOAD_REQ = 0, pause = 0, drop = 0;
  logic PAUSE_REQ, hs_write, hs_access, BUF_WE, BUSY, DONE, ERR;
  logic [15:0] hs_address;
  logic [7:0] hs_data_in, hs_data_out, BUF_ADR, BUF_DIN, BUF_DOUT;
  logic [7:0] vram [2048];
  logic [7:0] hbuf [256];
  logic [23:0] exp_q[$], wq[$], bq[$];
  int vectors = 0, errors = 0, lat;
  bit tmo, hi_bad, err_seen, preq1;

  always #5 ROMCL = ~ROMCL;

  ninjakun_hiscore_xfer #(.HS_BASE(BASE), .HS_LEN(LEN), .GUARD(GUARD)) dut (
    .ROMCL(ROMCL), .RESET_L(RESET_L), .SAVE_REQ(SAVE_REQ), .LOAD_REQ(LOAD_REQ),
    .PAUSE_REQ(PAUSE_REQ), .pause(pause), .hs_address(hs_address), .hs_data_in(hs_data_in),
    .hs_data_out(hs_data_out), .hs_write(hs_write), .hs_access(hs_access), .BUF_ADR(BUF_ADR),
    .BUF_DIN(BUF_DIN), .BUF_DOUT(BUF_DOUT), .BUF_WE(BUF_WE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always @(posedge ROMCL) begin
    if (hs_write) vram[hs_address[10:0]] <= hs_data_in;
    hs_data_out <= vram[hs_address[10:0]];
    if (BUF_WE) hbuf[BUF_ADR] <= BUF_DOUT;
    BUF_DIN <= hbuf[BUF_ADR];
    pause <= PAUSE_REQ & ~drop;
  end

  task automatic run(input bit s, input bit l, input int drop_after, input int ld_at, input bit corrupt);
    bit c = corrupt;
    logic [10:0] a5 = BASE + 11'd5;
    wq.delete(); bq.delete();
    hi_bad = 0; err_seen = 0; tmo = 1; lat = 0;
    repeat (2) @(negedge ROMCL);
    SAVE_REQ = s; LOAD_REQ = l;
    @(posedge ROMCL); lat = 1;
    @(negedge ROMCL);
    SAVE_REQ = 0; LOAD_REQ = 0; preq1 = PAUSE_REQ;
    for (int k = 0; k < 400; k++) begin
      LOAD_REQ = (lat == ld_at);
      if (hs_address[15:11] != 5'd0) hi_bad = 1;
      if (hs_write) wq.push_back({hs_address, hs_data_in});
      if (BUF_WE) bq.push_back({8'h00, BUF_ADR, BUF_DOUT});
      if (drop_after > 0 && wq.size() == drop_after) drop = 1;
      if (c && wq.size() == LEN) begin vram[a5] = vram[a5] ^ 8'hFF; c = 0; end
      if (DONE) begin err_seen = ERR; tmo = 0; break; end
      @(posedge ROMCL); lat++;
      @(negedge ROMCL);
    end
    LOAD_REQ = 0; drop = 0;
  endtask

  task automatic test_reset();
    RESET_L = 0;
    repeat (3) @(negedge ROMCL);
    vectors++;
    if ({PAUSE_REQ, hs_write, hs_access, BUF_WE, BUSY, DONE, ERR} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0000000", {PAUSE_REQ, hs_write, hs_access, BUF_WE, BUSY, DONE, ERR});
    end
    vectors++;
    if ({hs_address, hs_data_in, BUF_ADR, BUF_DOUT} !== 40'h0) begin
      errors++; $display("FAIL reset_buses got %h want 0", {hs_address, hs_data_in, BUF_ADR, BUF_DOUT});
    end
    RESET_L = 1;
  endtask

  task automatic test_save(input int ld_at);
    logic [23:0] o, e;
    for (int i = 0; i < 256; i++) hbuf[i] = 8'hFF;
    for (int i = 0; i < LEN; i++) begin
      logic [10:0] a = BASE + 11'(i);
      vram[a] = 8'(i * 7 + 1);
      exp_q.push_back({8'h00, 8'(i), 8'(i * 7 + 1)});
    end
    run(1, 0, 0, ld_at, 0);
    vectors++; if (tmo) begin errors++; $display("FAIL save_timeout no DONE within budget"); end
    vectors++; if (lat !== 39) begin errors++; $display("FAIL save_latency got %0d want 39", lat); end
    vectors++; if (preq1 !== 1'b1) begin errors++; $display("FAIL save_pause_req got %b want 1", preq1); end
    vectors++; if (err_seen !== 1'b0) begin errors++; $display("FAIL save_err got %b want 0", err_seen); end
    vectors++; if (wq.size() != 0) begin errors++; $display("FAIL save_vram_writes got %0d want 0", wq.size()); end
    vectors++; if (bq.size() != LEN) begin errors++; $display("FAIL save_buf_writes got %0d want %0d", bq.size(), LEN); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (bq.size() > 0) ? bq.pop_front() : 24'hFFFFFF;
      vectors++; if (o !== e) begin errors++; $display("FAIL save_byte got %h want %h", o, e); end
    end
    for (int i = 0; i < LEN; i++) begin
      vectors++; if (hbuf[i] !== 8'(i * 7 + 1)) begin errors++; $display("FAIL save_buffer[%0d] got %h want %h", i, hbuf[i], 8'(i * 7 + 1)); end
    end
    vectors++; if (hbuf[LEN] !== 8'hFF) begin errors++; $display("FAIL save_overrun got %h want ff", hbuf[LEN]); end
  endtask

  task automatic test_load();
    logic [23:0] o, e;
    for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
    for (int i = 0; i < LEN; i++) begin
      logic [10:0] a = BASE + 11'(i);
      hbuf[i] = 8'hA0 + 8'(i);
      exp_q.push_back({5'b0, a, 8'hA0 + 8'(i)});
    end
    run(0, 1, 0, 0, 0);
    vectors++; if (tmo) begin errors++; $display("FAIL load_timeout no DONE within budget"); end
    vectors++; if (lat !== LOAD_LAT) begin errors++; $display("FAIL load_latency got %0d want %0d", lat, LOAD_LAT); end
    vectors++; if (err_seen !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", err_seen); end
    vectors++; if (hi_bad) begin errors++; $display("FAIL load_addr_hi got nonzero want 0"); end
    vectors++; if (bq.size() != 0) begin errors++; $display("FAIL load_buf_writes got %0d want 0", bq.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (wq.size() > 0) ? wq.pop_front() : 24'hFFFFFF;
      vectors++; if (o !== e) begin errors++; $display("FAIL load_byte got %h want %h", o, e); end
    end
    vectors++; if (vram[11'h7FF] !== 8'hA7) begin errors++; $display("FAIL load_vram_7ff got %h want a7", vram[11'h7FF]); end
    vectors++; if (vram[11'h000] !== 8'hA8) begin errors++; $display("FAIL load_vram_wrap got %h want a8", vram[11'h000]); end
    vectors++; if (vram[11'h008] !== 8'h00) begin errors++; $display("FAIL load_vram_overrun got %h want 00", vram[11'h008]); end
  endtask

  task automatic test_both();
    for (int i = 0; i < LEN; i++) begin
      logic [10:0] a = BASE + 11'(i);
      vram[a] = 8'h50 + 8'(i);
      hbuf[i] = 8'hFF;
    end
    run(1, 1, 0, 0, 0);
    vectors++; if (wq.size() != 0) begin errors++; $display("FAIL both_vram_writes got %0d want 0", wq.size()); end
    vectors++; if (bq.size() != LEN) begin errors++; $display("FAIL both_buf_writes got %0d want %0d", bq.size(), LEN); end
    vectors++; if (hbuf[3] !== 8'h53) begin errors++; $display("FAIL both_buffer got %h want 53", hbuf[3]); end
  endtask

  task automatic test_back_to_back();
    test_save(10);
    repeat (4) @(negedge ROMCL);
    vectors++; if (BUSY !== 1'b0) begin errors++; $display("FAIL busy_load_ignored got BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_abort();
    logic [10:0] a3 = BASE + 11'd3;
    for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
    for (int i = 0; i < LEN; i++) hbuf[i] = 8'h30 + 8'(i);
    run(0, 1, 3, 0, 0);
    vectors++; if (tmo) begin errors++; $display("FAIL abort_timeout no DONE within budget"); end
    vectors++; if (wq.size() != 3) begin errors++; $display("FAIL abort_writes got %0d want 3", wq.size()); end
    vectors++; if (err_seen !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", err_seen); end
    vectors++; if (vram[a3] !== 8'h00) begin errors++; $display("FAIL abort_byte3 got %h want 00", vram[a3]); end
  endtask

`ifdef HISCORE_VERIFY_EN
  task automatic test_verify();
    for (int i = 0; i < LEN; i++) hbuf[i] = 8'hC0 + 8'(i);
    run(0, 1, 0, 0, 1);
    vectors++; if (err_seen !== 1'b1) begin errors++; $display("FAIL verify_corrupt_err got %b want 1", err_seen); end
    run(0, 1, 0, 0, 0);
    vectors++; if (err_seen !== 1'b0) begin errors++; $display("FAIL verify_clean_err got %b want 0", err_seen); end
    vectors++; if (lat !== LOAD_LAT) begin errors++; $display("FAIL verify_latency got %0d want %0d", lat, LOAD_LAT); end
  endtask
`endif

  task automatic test_reset_mid();
    bit bad = 0;
    repeat (2) @(negedge ROMCL);
    SAVE_REQ = 1;
    @(negedge ROMCL);
    SAVE_REQ = 0;
    repeat (20) @(negedge ROMCL);
    RESET_L = 0;
    @(negedge ROMCL);
    vectors++;
    if ({hs_access, PAUSE_REQ, BUSY, DONE, BUF_WE, hs_write} !== 6'b0) begin
      errors++; $display("FAIL reset_mid_outputs got %b want 000000", {hs_access, PAUSE_REQ, BUSY, DONE, BUF_WE, hs_write});
    end
    repeat (2) @(negedge ROMCL);
    RESET_L = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge ROMCL);
      if (DONE || BUSY) bad = 1;
    end
    vectors++; if (bad) begin errors++; $display("FAIL reset_mid_done got activity want none"); end
    test_save(0);
  endtask

  initial begin
    test_reset();
    test_save(0);
    test_load();
    test_both();
    test_back_to_back();
    test_abort();
`ifdef HISCORE_VERIFY_EN
    test_verify();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ninjakun_hiscore_xfer.md
# ninjakun_hiscore_xfer

Initiator for the foreground-VRAM high-score port of the shared I/O/video block. On a save or load request it pauses the game, takes the hs_* port, and copies an HS_LEN-byte window of foreground VRAM to or from an external byte buffer (NVRAM/ioctl side). It then releases the port and unpauses. It sits in the top level on the ROMCL domain, between the hiscore buffer and the hs_* inputs of the I/O/video block.

## Interface
Parameters:
- HS_BASE, 11'h000, first foreground-VRAM byte address of the window
- HS_LEN, 16, window length in bytes, legal 1..256
- GUARD, 2, idle cycles with hs_access=1 and hs_write=0 before the first access and after the last access (clock-mux settle)

Ports (one clock; reset is synchronous and active-low):
- ROMCL  in  1  clock; also clocks fgv RAM while hs_access=1
- RESET_L  in  1  synchronous active-low reset
- SAVE_REQ  in  1  one-cycle pulse, start VRAM->buffer copy
- LOAD_REQ  in  1  one-cycle pulse, start buffer->VRAM copy
- PAUSE_REQ  out  1  asks the core to pause
- pause  in  1  pause acknowledge, the core's current pause state
- hs_address  out  16  VRAM byte address, upper 5 bits always 0
- hs_data_in  out  8  write data to VRAM
- hs_data_out  in  8  VRAM read data, valid 1 cycle after hs_address
- hs_write  out  1  VRAM write strobe
- hs_access  out  1  port ownership
- BUF_ADR  out  8  buffer byte index
- BUF_DIN  in  8  buffer read data, valid 1 cycle after BUF_ADR
- BUF_DOUT  out  8  buffer write data
- BUF_WE  out  1  buffer write strobe
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse at completion
- ERR  out  1  one-cycle pulse coincident with DONE on abort or verify mismatch

## Operation
- Reset values: all outputs 0; state IDLE; byte counter i=0.
- IDLE: on SAVE_REQ go to REQ with dir=save. On LOAD_REQ go to REQ with dir=load. If both are high, SAVE wins. Requests outside IDLE are ignored.
- REQ: PAUSE_REQ=1 and BUSY=1. Wait for pause=1, then go to GUARD_IN.
- GUARD_IN: hs_access=1 for GUARD cycles, then go to XFER_A with i=0.
- Save, 2 cycles per byte:
  - XFER_A: hs_address=HS_BASE+i.
  - XFER_B: BUF_ADR=i, BUF_DOUT=hs_data_out, BUF_WE=1.
- Load, 2 cycles per byte:
  - XFER_A: BUF_ADR=i.
  - XFER_B: hs_address=HS_BASE+i, hs_data_in=BUF_DIN, hs_write=1.
- After XFER_B of byte HS_LEN-1, go to GUARD_OUT (or to VERIFY; see Configuration). Otherwise increment i and go to XFER_A.
- GUARD_OUT: hs_access=1 and hs_write=0 for GUARD cycles, then FIN.
- FIN: hs_access=0, PAUSE_REQ=0, DONE=1 for one cycle, ERR=1 if the error flag is set. Then go to IDLE with BUSY=0.
- Address arithmetic: the 11-bit sum HS_BASE+i wraps mod 2048. hs_address={5'b0,sum}.
- Abort: if pause drops while in GUARD_IN, XFER or VERIFY, set the error flag and go to GUARD_OUT. The current byte's strobe is suppressed.
- PAUSE_REQ stays 1 from REQ through GUARD_OUT inclusive.

## Timing
- Request to PAUSE_REQ: 1 cycle.
- Transfer length (pause already high): 1 (REQ) + GUARD + 2·HS_LEN + GUARD + 1 (FIN) cycles from the request-sampled edge to DONE.
- hs_write and BUF_WE are single-cycle strobes, each on its own cycle. hs_address is stable during hs_write.
- hs_access never toggles while hs_write=1.
- Reset asserted mid-transfer: all outputs 0 on the next edge. No DONE.

## Configuration
- HISCORE_VERIFY_EN defined: after a load, a VERIFY pass runs, 2 cycles per byte.
  - VA: BUF_ADR=i and hs_address=HS_BASE+i.
  - VB: compare BUF_DIN with hs_data_out; on inequality set the error flag.
  - After the last byte, go to GUARD_OUT.
  - Adds 2·HS_LEN cycles to a load.
- HISCORE_VERIFY_EN undefined: load goes directly from the last XFER_B to GUARD_OUT, and ERR only reports an abort.

## Test plan
- Save, HS_BASE=11'h3F0, HS_LEN=16, GUARD=2, VRAM[3F0..3FF]=00..0F, pause tied to PAUSE_REQ 1 cycle later:
  - buffer[0..15]=00..0F;
  - DONE exactly 39 cycles after SAVE_REQ;
  - ERR=0.
- Load with buffer[i]=A0+i, HS_BASE=11'h7FC, HS_LEN=8:
  - VRAM[7FC..7FF]=A0..A3 and VRAM[000..003]=A4..A7 (wrap);
  - hs_address[15:11]=0 throughout.
- SAVE_REQ and LOAD_REQ in the same cycle -> save performed, no VRAM write. A LOAD_REQ during BUSY is ignored.
- Pause deasserted after 3 bytes of a load -> 3 hs_write pulses only, GUARD_OUT, then DONE=ERR=1.
- HISCORE_VERIFY_EN defined, bench corrupts VRAM byte 5 after the write -> ERR=1 with DONE. With no corruption -> ERR=0 and load length grows by 2·HS_LEN.
- RESET_L low mid-save -> next cycle hs_access=PAUSE_REQ=BUSY=0, no DONE. The next SAVE_REQ completes normally.
